// File: rtl/led_seq_pkg.sv
// Shared mode encoding, start patterns and sizing for the LED mode sequencer.
// Optional feature: define LED_SEQ_BOUNCE_EN to include the BOUNCE mode.
package led_seq_pkg;

`ifdef LED_SEQ_BOUNCE_EN
    typedef enum logic [1:0] {
        MODE_ROTATE = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_ALL_ON = 2'd3
    } mode_t;
`else
    typedef enum logic [1:0] {
        MODE_ROTATE = 2'd0,
        MODE_BLINK  = 2'd2,
        MODE_ALL_ON = 2'd3
    } mode_t;
`endif

    localparam int TICK_DIV_DEFAULT       = 131072;
    localparam int DEBOUNCE_TICKS_DEFAULT = 3;
    localparam int PRESCALER_W            = 24;
    localparam int DEBOUNCE_CNT_W         = 4;
    localparam int PAT_W                  = 4;

    localparam logic [PAT_W-1:0] START_ROTATE = 4'b0001;
`ifdef LED_SEQ_BOUNCE_EN
    localparam logic [PAT_W-1:0] START_BOUNCE = 4'b0001;
`endif
    localparam logic [PAT_W-1:0] START_BLINK  = 4'b0000;
    localparam logic [PAT_W-1:0] START_ALL_ON = 4'b1111;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
`ifdef LED_SEQ_BOUNCE_EN
            MODE_ROTATE: next_mode = MODE_BOUNCE;
            MODE_BOUNCE: next_mode = MODE_BLINK;
`else
            MODE_ROTATE: next_mode = MODE_BLINK;
`endif
            MODE_BLINK:  next_mode = MODE_ALL_ON;
            MODE_ALL_ON: next_mode = MODE_ROTATE;
            default:     next_mode = MODE_ROTATE;
        endcase
    endfunction

    function automatic logic [PAT_W-1:0] start_pattern(input mode_t m);
        case (m)
            MODE_ROTATE: start_pattern = START_ROTATE;
`ifdef LED_SEQ_BOUNCE_EN
            MODE_BOUNCE: start_pattern = START_BOUNCE;
`endif
            MODE_BLINK:  start_pattern = START_BLINK;
            MODE_ALL_ON: start_pattern = START_ALL_ON;
            default:     start_pattern = START_ROTATE;
        endcase
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, tick-sampled debounce counter and rising-edge press pulse.
// The press pulse is combinational so it lands in the same cycle as the accepting tick.
module button_debounce
    import led_seq_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic button,
    input  logic tick,
    output logic level,
    output logic press
);

    logic [1:0]                sync_reg;
    logic [DEBOUNCE_CNT_W-1:0] cnt_reg;
    logic [DEBOUNCE_CNT_W-1:0] cnt_next;
    logic                      level_reg;
    logic                      level_next;
    logic                      sample;

    assign sample = sync_reg[1];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_reg  <= '0;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], button};
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
        end
    end

    // A sample agreeing with the current level breaks the run and restarts the count.
    always_comb begin
        cnt_next   = cnt_reg;
        level_next = level_reg;
        if (tick) begin
            if (sample != level_reg) begin
                if (cnt_reg == DEBOUNCE_CNT_W'(DEBOUNCE_TICKS - 1)) begin
                    level_next = sample;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + DEBOUNCE_CNT_W'(1);
                end
            end else begin
                cnt_next = '0;
            end
        end
    end

    assign press = level_next & ~level_reg;
    assign level = level_reg;

endmodule

// File: rtl/led_mode_sequencer.sv
// Button-driven LED pattern sequencer: prescaler tick, mode FSM and 4-bit pattern register.
// Optional feature: define LED_SEQ_BOUNCE_EN to include the BOUNCE mode and its direction flag.
module led_mode_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV       = TICK_DIV_DEFAULT,
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic BUTTON,
    output logic LED1,
    output logic LED2,
    output logic LED3,
    output logic LED4,
    output logic LED5
);

    logic [PRESCALER_W-1:0] prescaler_reg;
    logic [PRESCALER_W-1:0] prescaler_next;
    mode_t                  mode_reg;
    mode_t                  mode_next;
    logic [PAT_W-1:0]       pat_reg;
    logic [PAT_W-1:0]       pat_next;
`ifdef LED_SEQ_BOUNCE_EN
    logic                   dir_up_reg;
    logic                   dir_up_next;
`endif
    logic                   tick;
    logic                   press;
    logic                   level;

    assign tick = (prescaler_reg == PRESCALER_W'(TICK_DIV - 1));

    button_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_button_debounce (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .button (BUTTON),
        .tick   (tick),
        .level  (level),
        .press  (press)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            prescaler_reg <= '0;
            mode_reg      <= MODE_ROTATE;
            pat_reg       <= START_ROTATE;
`ifdef LED_SEQ_BOUNCE_EN
            dir_up_reg    <= 1'b1;
`endif
        end else begin
            prescaler_reg <= prescaler_next;
            mode_reg      <= mode_next;
            pat_reg       <= pat_next;
`ifdef LED_SEQ_BOUNCE_EN
            dir_up_reg    <= dir_up_next;
`endif
        end
    end

    // A press wins over a coincident tick: load the start pattern, take no step.
    always_comb begin
        mode_next      = mode_reg;
        pat_next       = pat_reg;
        prescaler_next = tick ? '0 : prescaler_reg + PRESCALER_W'(1);
`ifdef LED_SEQ_BOUNCE_EN
        dir_up_next    = dir_up_reg;
`endif
        if (press) begin
            mode_next      = next_mode(mode_reg);
            pat_next       = start_pattern(next_mode(mode_reg));
            prescaler_next = '0;
`ifdef LED_SEQ_BOUNCE_EN
            dir_up_next    = 1'b1;
`endif
        end else if (tick) begin
            case (mode_reg)
                MODE_ROTATE: pat_next = {pat_reg[PAT_W-2:0], pat_reg[PAT_W-1]};
`ifdef LED_SEQ_BOUNCE_EN
                MODE_BOUNCE: begin
                    // Direction flips on the same edge the pattern reaches an end.
                    if (dir_up_reg) begin
                        pat_next = {pat_reg[PAT_W-2:0], 1'b0};
                        if (pat_next == 4'b1000) begin
                            dir_up_next = 1'b0;
                        end
                    end else begin
                        pat_next = {1'b0, pat_reg[PAT_W-1:1]};
                        if (pat_next == 4'b0001) begin
                            dir_up_next = 1'b1;
                        end
                    end
                end
`endif
                MODE_BLINK:  pat_next = ~pat_reg;
                MODE_ALL_ON: pat_next = START_ALL_ON;
                default:     pat_next = pat_reg;
            endcase
        end
    end

    assign LED1 = pat_reg[0];
    assign LED2 = pat_reg[1];
    assign LED3 = pat_reg[2];
    assign LED4 = pat_reg[3];
    assign LED5 = level;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer (TICK_DIV=4, DEBOUNCE_TICKS=3); expectations follow
// LED_SEQ_BOUNCE_EN so the same bench covers both builds.
module tb_led_mode_sequencer;

    localparam int TICK_DIV       = 4;
    localparam int DEBOUNCE_TICKS = 3;
    localparam int NUM_TICKS      = 45;

    logic CLK = 1'b0;
    logic RESET_N;
    logic BUTTON;
    logic LED1;
    logic LED2;
    logic LED3;
    logic LED4;
    logic LED5;
    logic [3:0] leds;

    int err_count   = 0;
    int check_count = 0;

    // Button level driven right after tick k (bit k), sampled at tick k+1.
    logic [44:0]     btn_sched;
    logic [45:1]     led5_exp;
    logic [3:0]      pat_exp [1:NUM_TICKS];

    assign leds = {LED4, LED3, LED2, LED1};

    led_mode_sequencer #(
        .TICK_DIV      (TICK_DIV),
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .BUTTON (BUTTON),
        .LED1   (LED1),
        .LED2   (LED2),
        .LED3   (LED3),
        .LED4   (LED4),
        .LED5   (LED5)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Release reset between edges, then: 0001 through edge 3, 0010 at edge 4, 0100 at edge 8.
    task automatic release_and_check(input string tag);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_val({tag, " pat before first tick"}, 32'(leds), 32'h1);
        check_val({tag, " led5 before first tick"}, 32'(LED5), 32'h0);
        @(posedge CLK);
        #1;
        $display("tick 1 button=%b leds=%b led5=%b", BUTTON, leds, LED5);
        check_val({tag, " pat tick1"}, 32'(leds), 32'h2);
        check_val({tag, " led5 tick1"}, 32'(LED5), 32'h0);
        repeat (TICK_DIV) @(posedge CLK);
        #1;
        $display("tick 2 button=%b leds=%b led5=%b", BUTTON, leds, LED5);
        check_val({tag, " pat tick2"}, 32'(leds), 32'h4);
        check_val({tag, " led5 tick2"}, 32'(LED5), 32'h0);
    endtask

    initial begin
        btn_sched = 45'b01110_00111_00001_11000_11100_01110_00000_01110_01100;
        led5_exp  = 45'b11000_11100_00111_00011_10001_11000_00001_11000_00000;
`ifdef LED_SEQ_BOUNCE_EN
        pat_exp = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1,
                    4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4, 4'h8,
                    4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF,
                    4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                    4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4,
                    4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2,
                    4'h0, 4'hF};
`else
        pat_exp = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1,
                    4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF,
                    4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                    4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2,
                    4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0,
                    4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                    4'h1, 4'h2};
`endif

        RESET_N = 1'b0;
        BUTTON  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_val("reset pat", 32'(leds), 32'h1);
        check_val("reset led5", 32'(LED5), 32'h0);
        check_val("reset prescaler", 32'(dut.prescaler_reg), 32'h0);

        release_and_check("first release");
        BUTTON = btn_sched[2];

        for (int t = 3; t <= NUM_TICKS; t++) begin
            repeat (TICK_DIV) @(posedge CLK);
            #1;
            $display("tick %0d button=%b leds=%b led5=%b", t, BUTTON, leds, LED5);
            check_val($sformatf("pat tick%0d", t), 32'(leds), 32'(pat_exp[t]));
            check_val($sformatf("led5 tick%0d", t), 32'(LED5), 32'(led5_exp[t]));
            if (t == 38) begin
                check_val("prescaler cleared on press", 32'(dut.prescaler_reg), 32'h0);
            end
            if (t < NUM_TICKS) begin
                BUTTON = btn_sched[t];
            end
        end

        // Asynchronous reset between clock edges, with LED5 currently high.
        #2;
        RESET_N = 1'b0;
        #1;
        check_val("async reset pat", 32'(leds), 32'h1);
        check_val("async reset led5", 32'(LED5), 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        check_val("held reset pat", 32'(leds), 32'h1);
        check_val("held reset prescaler", 32'(dut.prescaler_reg), 32'h0);

        release_and_check("second release");

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
